// File: rtl/hamming_engine.sv
// Memory-walking Hamming (15,11) codec: reads two-byte messages from src, encodes or
// decodes/corrects them, and writes the results to dst, with optional SECDED checking.
//   state | meaning
//   IDLE  | waiting for req after reset
//   RD_LO | reading low byte at src+2i
//   RD_HI | reading high byte at src+2i+1; result formed from both bytes
//   WR_LO | writing low result byte to dst+2i
//   WR_HI | writing high result byte to dst+2i+1
//   DONE  | run finished, ack high, waiting for req
module hamming_engine #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int NMSG   = 15,
  parameter int SECDED = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          mode,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic          ack,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wr_data,
  output logic [7:0]    corr_cnt,
  output logic [7:0]    ded_cnt
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t        state;
  logic          mode_q;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [6:0]    idx;
  logic [7:0]    lo_q;
  logic [7:0]    res_hi_q;

  logic [16:1] cw;
  logic [11:1] d_in;
  logic [15:1] enc_c;
  logic        enc_c16;
  logic [3:0]  syn;
  logic        par_all;
  logic        is_ded;
  logic        do_fix;
  logic [15:1] fix_mask;
  logic [15:1] cw_fix;
  logic [11:1] d_out;
  logic [7:0]  res_lo;
  logic [7:0]  res_hi;

  // Result is formed in RD_HI from the captured low byte and the live high byte.
  always_comb begin
    cw          = {mem_rd_data[7:0], lo_q};
    d_in        = {mem_rd_data[2:0], lo_q};
    enc_c[1]    = d_in[11] ^ d_in[9] ^ d_in[7] ^ d_in[5] ^ d_in[4] ^ d_in[2] ^ d_in[1];
    enc_c[2]    = d_in[11] ^ d_in[10] ^ d_in[7] ^ d_in[6] ^ d_in[4] ^ d_in[3] ^ d_in[1];
    enc_c[3]    = d_in[1];
    enc_c[4]    = ^{d_in[11:8], d_in[4:2]};
    enc_c[7:5]  = d_in[4:2];
    enc_c[8]    = ^d_in[11:5];
    enc_c[15:9] = d_in[11:5];
    enc_c16     = (SECDED != 0) ? ^enc_c : 1'b0;

    syn = 4'd0;
    for (int k = 1; k <= 15; k++) begin
      if (cw[k]) syn = syn ^ 4'(k);
    end
    par_all  = ^cw;
    is_ded   = (SECDED != 0) && (syn != 4'd0) && !par_all;
    do_fix   = (syn != 4'd0) && !is_ded;
    fix_mask = '0;
    for (int k = 1; k <= 15; k++) begin
      fix_mask[k] = do_fix && (syn == 4'(k));
    end
    cw_fix = cw[15:1] ^ fix_mask;
    d_out  = {cw_fix[15:9], cw_fix[7:5], cw_fix[3]};

    if (mode_q) begin
      res_lo = d_out[8:1];
      res_hi = {is_ded, 4'b0000, d_out[11:9]};
    end else begin
      res_lo = enc_c[8:1];
      res_hi = {enc_c16, enc_c[15:9]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ack         <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      corr_cnt    <= 8'd0;
      ded_cnt     <= 8'd0;
      mode_q      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      idx         <= 7'd0;
      lo_q        <= 8'd0;
      res_hi_q    <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (req) begin
            mode_q   <= mode;
            rd_ptr   <= src_base;
            wr_ptr   <= dst_base;
            idx      <= 7'd0;
            ack      <= 1'b0;
            corr_cnt <= 8'd0;
            ded_cnt  <= 8'd0;
            mem_addr <= src_base;
            state    <= RD_LO;
          end
        end
        RD_LO: begin
          lo_q     <= mem_rd_data[7:0];
          mem_addr <= rd_ptr + AW'(1);
          state    <= RD_HI;
        end
        RD_HI: begin
          mem_wr_data <= res_lo;
          res_hi_q    <= res_hi;
          mem_addr    <= wr_ptr;
          mem_wr_en   <= 1'b1;
          if (mode_q && do_fix && corr_cnt != 8'hFF) corr_cnt <= corr_cnt + 8'd1;
          if (mode_q && is_ded && ded_cnt != 8'hFF) ded_cnt <= ded_cnt + 8'd1;
          state       <= WR_LO;
        end
        WR_LO: begin
          mem_wr_data <= res_hi_q;
          mem_addr    <= wr_ptr + AW'(1);
          state       <= WR_HI;
        end
        WR_HI: begin
          mem_wr_en <= 1'b0;
          if (idx == 7'(NMSG - 1)) begin
            ack   <= 1'b1;
            state <= DONE;
          end else begin
            idx      <= idx + 7'd1;
            rd_ptr   <= rd_ptr + AW'(2);
            wr_ptr   <= wr_ptr + AW'(2);
            mem_addr <= rd_ptr + AW'(2);
            state    <= RD_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
